instr_fetch_stage: RTL

Instruction-fetch stage sitting directly downstream of the program-counter controller. It issues a memory request at the current `pc`, waits for the response, and loads the IF/ID pipeline register. It returns a one-cycle `pc_enable` pulse to the PC controller when an instruction is accepted. Stall and flush from decode/hazard logic are absorbed here, and squashed slots are presented downstream as NOP bubbles.

---
 rtl/instr_fetch_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: requests the instruction at pc, waits for the response and loads the IF/ID register.
// Latency: IF/ID loads on the edge that ends the response cycle, or the stall-release cycle; best case is 1 instruction per 2 cycles.
// Backpressure: the valid/ready request waits on imem_req_ready; stall parks a response in a one-entry buffer; flush squashes it to a bubble.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   pc                                fetch address from the PC controller, stable between pc_enable pulses
//   pc_enable                         one-cycle pulse for each instruction accepted into IF/ID
//   imem_req_valid/ready, imem_addr   request channel to instruction memory
//   imem_resp_valid, imem_resp_data   response channel, one response per accepted request
//   stall, flush                      decode/hazard control
//   if_instr, if_pc, if_pc4, if_valid IF/ID pipeline register
//   is_nop                            ~if_valid
//
// Optional build macro IFETCH_PERF_CNT_EN adds the output fetch_stall_cycles.
// This saturating counter counts the cycles spent in WAIT, HOLD or DROP.

module instr_fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_enable,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        is_nop
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] buf_dat;
  logic        buf_we;
  logic        load_en;
  logic [31:0] load_dat;

  // pc does not change until pc_enable pulses, so the live pc is the
  // address of the outstanding request. It also serves as the address of
  // whatever IF/ID loads.
  assign imem_addr = pc;
  assign is_nop    = ~if_valid;

  always_comb begin
    state_nxt      = state;
    pc_enable      = 1'b0;
    imem_req_valid = 1'b0;
    buf_we         = 1'b0;
    load_en        = 1'b0;
    load_dat       = buf_dat;

    case (state)
      REQ: begin
        // In this state, flush only bubbles IF/ID. The request stays up.
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (flush) begin
          // If the response has not arrived yet, it is still owed. It must
          // be absorbed in DROP.
          state_nxt = imem_resp_valid ? REQ : DROP;
        end else if (imem_resp_valid) begin
          if (stall) begin
            buf_we    = 1'b1;
            state_nxt = HOLD;
          end else begin
            load_en   = 1'b1;
            load_dat  = imem_resp_data;
            pc_enable = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_nxt = REQ;
        end else if (!stall) begin
          load_en   = 1'b1;
          load_dat  = buf_dat;
          pc_enable = 1'b1;
          state_nxt = REQ;
        end
      end
      DROP: begin
        if (imem_resp_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase

    // The PC controller and the memory must see nothing while reset is held.
    if (rst) begin
      pc_enable      = 1'b0;
      imem_req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      buf_dat  <= 32'd0;
      if_instr <= NOP_INSTR;
      if_pc    <= 32'd0;
      if_pc4   <= 32'd4;
      if_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (buf_we) buf_dat <= imem_resp_data;
      if (flush) begin
        // Flush takes priority over stall. The pc fields are left alone
        // because if_valid=0 already marks the slot as empty.
        if_instr <= NOP_INSTR;
        if_valid <= 1'b0;
      end else if (load_en) begin
        if_instr <= load_dat;
        if_pc    <= pc;
        if_pc4   <= pc + 32'd4;
        if_valid <= 1'b1;
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_stall_cycles <= 32'd0;
    end else if ((state != REQ) && (fetch_stall_cycles != 32'hFFFF_FFFF)) begin
      fetch_stall_cycles <= fetch_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
